// File: rtl/fmap_stream_collector.sv
// fmap_stream_collector: captures one raster-order feature map from a layer
// output stream (no backpressure) and replays it as a valid/ready stream.
module fmap_stream_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int CH         = 16,
  parameter int WIDTH      = 28
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DATA_WIDTH*CH-1:0]              i_data,
  input  logic                                  valid_in,
  input  logic                                  start,
  input  logic                                  ready_in,
  output logic [DATA_WIDTH*CH-1:0]              o_data,
  output logic                                  valid_out,
  output logic                                  frame_full,
  output logic                                  frame_done,
  output logic                                  read_done,
  output logic                                  overflow,
  output logic [$clog2(WIDTH*WIDTH+1)-1:0]      wr_count
);

  localparam int DEPTH = WIDTH * WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int DW    = DATA_WIDTH * CH;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [CW-1:0]   rd_addr_q, rd_addr_d;
  logic [CW-1:0]   wr_count_q, wr_count_d;
  logic            pend_q, pend_d;
  logic            out_v_q, out_v_d;
  logic            skid_v_q, skid_v_d;
  logic            frame_done_q, frame_done_d;
  logic            read_done_q, read_done_d;
  logic            overflow_q, overflow_d;
  logic [DW-1:0]   out_q, out_d;
  logic [DW-1:0]   skid_q, skid_d;
  logic [DW-1:0]   mem_q;

  logic [DW-1:0]   mem [DEPTH];

  logic            wr_en;
  logic            wr_last;
  logic            rd_en;
  logic            pop;
  logic            last_pop;
  logic [1:0]      occ;

  // Read issue, handshake and end-of-frame qualifiers.
  always_comb begin
    wr_en    = (state_q == FILL) && valid_in;
    wr_last  = wr_en && (wr_addr_q == AW'(DEPTH - 1));
    pop      = out_v_q && ready_in;
    occ      = 2'(out_v_q) + 2'(skid_v_q) + 2'(pend_q);
    // A read is issued only if output register plus skid can absorb it
    // after this cycle's pop, so the skid slot can never be overrun.
    rd_en    = (state_q == DRAIN) && (rd_addr_q < CW'(DEPTH)) &&
               ((occ - 2'(pop)) < 2'd2);
    last_pop = (state_q == DRAIN) && pop && (rd_addr_q == CW'(DEPTH)) &&
               !pend_q && !skid_v_q;
  end

  // Next-state and control/datapath next values.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    wr_count_d   = wr_count_q;
    pend_d       = 1'b0;
    out_v_d      = out_v_q;
    skid_v_d     = skid_v_q;
    out_d        = out_q;
    skid_d       = skid_q;
    frame_done_d = 1'b0;
    read_done_d  = 1'b0;
    overflow_d   = overflow_q | (valid_in && (state_q != FILL));

    unique case (state_q)
      FILL: begin
        if (wr_en) begin
          wr_count_d = wr_count_q + 1'b1;
          if (wr_last) begin
            wr_addr_d    = '0;
            frame_done_d = 1'b1;
            state_d      = FULL;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (start) begin
          state_d   = DRAIN;
          rd_addr_d = '0;
        end
      end
      DRAIN: begin
        pend_d = rd_en;
        if (rd_en) rd_addr_d = rd_addr_q + 1'b1;
        // Output slot refills from skid first, then from the read port;
        // when the slot is stalled, returning read data parks in the skid.
        if (!out_v_q || pop) begin
          if (skid_v_q) begin
            out_d   = skid_q;
            out_v_d = 1'b1;
            if (pend_q) skid_d = mem_q;
            else        skid_v_d = 1'b0;
          end else if (pend_q) begin
            out_d   = mem_q;
            out_v_d = 1'b1;
          end else begin
            out_v_d = 1'b0;
          end
        end else if (pend_q) begin
          skid_d   = mem_q;
          skid_v_d = 1'b1;
        end
        if (last_pop) begin
          out_v_d     = 1'b0;
          skid_v_d    = 1'b0;
          pend_d      = 1'b0;
          read_done_d = 1'b1;
          rd_addr_d   = '0;
          wr_count_d  = '0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_count_q   <= '0;
      pend_q       <= 1'b0;
      out_v_q      <= 1'b0;
      skid_v_q     <= 1'b0;
      frame_done_q <= 1'b0;
      read_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_count_q   <= wr_count_d;
      pend_q       <= pend_d;
      out_v_q      <= out_v_d;
      skid_v_q     <= skid_v_d;
      frame_done_q <= frame_done_d;
      read_done_q  <= read_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Data-only registers; contents are don't-care while their valid is low.
  always_ff @(posedge clk) begin
    out_q  <= out_d;
    skid_q <= skid_d;
  end

  // Frame buffer: one write port, one synchronous read port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr_q] <= i_data;
    if (rd_en) mem_q <= mem[rd_addr_q[AW-1:0]];
  end

  assign o_data     = out_q;
  assign valid_out  = out_v_q;
  assign frame_full = (state_q == FULL);
  assign frame_done = frame_done_q;
  assign read_done  = read_done_q;
  assign overflow   = overflow_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_fmap_stream_collector.sv
// Directed bench for fmap_stream_collector with a 4x4 map, 4 lanes of 8 bits.
module tb_fmap_stream_collector;

  localparam int DW = 8 * 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          valid_in = 1'b0;
  logic          start = 1'b0;
  logic          ready_in = 1'b0;
  logic [DW-1:0] o_data;
  logic          valid_out;
  logic          frame_full;
  logic          frame_done;
  logic          read_done;
  logic          overflow;
  logic [4:0]    wr_count;

  int checks = 0;
  int errors = 0;

  fmap_stream_collector #(
    .DATA_WIDTH (8),
    .CH         (4),
    .WIDTH      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .valid_in   (valid_in),
    .start      (start),
    .ready_in   (ready_in),
    .o_data     (o_data),
    .valid_out  (valid_out),
    .frame_full (frame_full),
    .frame_done (frame_done),
    .read_done  (read_done),
    .overflow   (overflow),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {4{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got %b exp 0", valid_out); end
    checks++; if (frame_full !== 1'b0) begin errors++; $display("FAIL reset_frame_full got %b exp 0", frame_full); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++; if (read_done !== 1'b0) begin errors++; $display("FAIL reset_read_done got %b exp 0", read_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (wr_count !== 5'd0) begin errors++; $display("FAIL reset_wr_count got %0d exp 0", wr_count); end
  endtask

  // Writes 16 words base..base+15 with 'gap' idle cycles between them.
  task automatic capture(input int gap, input int base, input bit start_last);
    for (int i = 0; i < 16; i++) begin
      valid_in = 1'b1;
      i_data   = word(base + i);
      start    = start_last && (i == 15);
      tick();
      valid_in = 1'b0;
      start    = 1'b0;
      checks++; if (wr_count !== 5'(i + 1)) begin errors++; $display("FAIL cap_wr_count word %0d got %0d exp %0d", i, wr_count, i + 1); end
      checks++; if (frame_done !== (i == 15)) begin errors++; $display("FAIL cap_frame_done word %0d got %b exp %b", i, frame_done, (i == 15)); end
      if (i < 15) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          checks++; if (wr_count !== 5'(i + 1)) begin errors++; $display("FAIL gap_wr_count word %0d got %0d exp %0d", i, wr_count, i + 1); end
        end
      end
    end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse got %b exp 0", frame_done); end
    checks++; if (frame_full !== 1'b1) begin errors++; $display("FAIL cap_frame_full got %b exp 1", frame_full); end
    checks++; if (wr_count !== 5'd16) begin errors++; $display("FAIL cap_wr_count_full got %0d exp 16", wr_count); end
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1.
  // stop_after > 0 ends the drain after that many handshakes.
  task automatic drain(input int mode, input int base, input int stop_after, input bit inject);
    int got = 0;
    int k = 0;
    int first_k = -1;
    int last_k = 0;
    bit done = 1'b0;
    logic [DW-1:0] held;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (frame_full !== 1'b0) begin errors++; $display("FAIL start_frame_full got %b exp 0", frame_full); end
    while (!done && k < 200) begin
      ready_in = (mode == 0) ? 1'b1 : (((k % 4) == 0) || ((k % 4) == 3));
      valid_in = inject;
      i_data   = word(8'hEE);
      if (valid_out && first_k < 0) begin
        first_k = k;
        checks++; if (k > 2) begin errors++; $display("FAIL first_valid_latency got %0d exp <=2", k); end
      end
      if (valid_out && ready_in) begin
        checks++; if (o_data !== word(base + got)) begin errors++; $display("FAIL drain_data idx %0d got %h exp %h", got, o_data, word(base + got)); end
        got++;
        last_k = k;
        tick();
        k++;
        if (got == 16) begin
          done = 1'b1;
          checks++; if (read_done !== 1'b1) begin errors++; $display("FAIL read_done got %b exp 1", read_done); end
          checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL end_valid_out got %b exp 0", valid_out); end
          checks++; if (wr_count !== 5'd0) begin errors++; $display("FAIL end_wr_count got %0d exp 0", wr_count); end
        end else begin
          if (stop_after > 0 && got == stop_after) done = 1'b1;
          checks++; if (read_done !== 1'b0) begin errors++; $display("FAIL early_read_done idx %0d got %b exp 0", got, read_done); end
        end
      end else if (valid_out) begin
        held = o_data;
        tick();
        k++;
        checks++; if (valid_out !== 1'b1 || o_data !== held) begin errors++; $display("FAIL stall_hold got v=%b %h exp v=1 %h", valid_out, o_data, held); end
      end else begin
        tick();
        k++;
      end
    end
    valid_in = 1'b0;
    ready_in = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d words exp %0d", got, (stop_after > 0) ? stop_after : 16);
    end else if (stop_after == 0) begin
      if (mode == 0) begin
        checks++; if (last_k - first_k + 1 != 16) begin errors++; $display("FAIL throughput got %0d cycles exp 16", last_k - first_k + 1); end
      end
      tick();
      checks++; if (read_done !== 1'b0) begin errors++; $display("FAIL read_done_pulse got %b exp 0", read_done); end
      checks++; if (frame_full !== 1'b0) begin errors++; $display("FAIL post_drain_frame_full got %b exp 0", frame_full); end
    end
  endtask

  task automatic test_capture_and_stream();
    capture(0, 0, 1'b1);
    tick(); tick(); tick();
    checks++; if (valid_out !== 1'b0 || frame_full !== 1'b1) begin errors++; $display("FAIL start_in_fill got v=%b full=%b exp v=0 full=1", valid_out, frame_full); end
    drain(0, 0, 0, 1'b0);
  endtask

  task automatic test_stalled_drain();
    capture(0, 0, 1'b0);
    drain(1, 0, 0, 1'b0);
  endtask

  task automatic test_gapped_capture();
    capture(2, 0, 1'b0);
    drain(0, 0, 0, 1'b0);
  endtask

  task automatic test_overflow();
    capture(0, 0, 1'b0);
    valid_in = 1'b1;
    i_data   = word(99);
    tick();
    valid_in = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_full got %b exp 1", overflow); end
    checks++; if (wr_count !== 5'd16) begin errors++; $display("FAIL overflow_wr_count got %0d exp 16", wr_count); end
    drain(0, 0, 0, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", overflow); end
    checks++; if (wr_count !== 5'd0) begin errors++; $display("FAIL overflow_no_capture got %0d exp 0", wr_count); end
  endtask

  task automatic test_reset_mid_drain();
    capture(0, 0, 1'b0);
    drain(0, 0, 5, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_reset_valid_out got %b exp 0", valid_out); end
    checks++; if (wr_count !== 5'd0) begin errors++; $display("FAIL mid_reset_wr_count got %0d exp 0", wr_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_overflow got %b exp 0", overflow); end
    capture(0, 16, 1'b0);
    drain(0, 16, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_capture_and_stream();
    test_stalled_drain();
    test_gapped_capture();
    test_overflow();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
